// File: rtl/pulse_sched_pkg.sv
// pulse_sched shared types: FSM state and counter width helper.
// Imported by the scheduler top.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } state_t;

  // Width for a counter that must hold max(p,g)-1, never below 1 bit.
  function automatic int cnt_w(input int p, input int g);
    int m;
    m = (p > g) ? p : g;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pulse_sched_if.sv
// pulse_sched bus: en/req in, pending/pulse_out/owner/busy/done out.
// master = requester side, slave = scheduler side.
// Optional overrun_cnt when PULSE_SCHED_OVERRUN_CNT_EN is defined.
interface pulse_sched_if #(
  parameter int N_REQ = 4
) ();
  localparam int IDW = $clog2(N_REQ);

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] pending;
  logic             pulse_out;
  logic [IDW-1:0]   owner;
  logic             busy;
  logic [N_REQ-1:0] done;
`ifdef PULSE_SCHED_OVERRUN_CNT_EN
  logic [7:0]       overrun_cnt;

  modport master (
    output en, req,
    input  pending, pulse_out, owner,
    input  busy, done, overrun_cnt
  );
  modport slave (
    input  en, req,
    output pending, pulse_out, owner,
    output busy, done, overrun_cnt
  );
`else
  modport master (
    output en, req,
    input  pending, pulse_out, owner,
    input  busy, done
  );
  modport slave (
    input  en, req,
    output pending, pulse_out, owner,
    output busy, done
  );
`endif

endinterface

// File: rtl/pulse_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports: pend, ptr (last winner) in; gnt one-hot, id, valid out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] id,
  output logic          valid
);

  // Search starts just past the last winner and wraps.
  always_comb begin
    int j;
    logic [IW-1:0] k;
    gnt   = '0;
    id    = '0;
    valid = 1'b0;
    j     = 0;
    k     = '0;
    for (int i = 1; i <= N; i++) begin
      j = (int'(ptr) + i) % N;
      k = IW'(j);
      if (!valid && pend[k]) begin
        valid  = 1'b1;
        gnt[k] = 1'b1;
        id     = k;
      end
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// pulse_sched: round-robin owner of one shared fixed-length pulse.
// Ports: clk, rst (sync, active-high), bus (pulse_sched_if.slave).
// Macro PULSE_SCHED_OVERRUN_CNT_EN adds bus.overrun_cnt.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PULSE_LEN = 32,
  parameter int GAP_LEN   = 2
) (
  input logic         clk,
  input logic         rst,
  pulse_sched_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = cnt_w(PULSE_LEN, GAP_LEN);
  localparam int GE  = (GAP_LEN > 0) ? GAP_LEN - 1 : 0;

  localparam logic [CW-1:0] P_END = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] G_END = CW'(GE);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   own;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] done;
  logic             pulse;
  logic             busy;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   win;
  logic             win_v;
  logic             grant;
  logic [N_REQ-1:0] clr;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IDW)
  ) u_arb (
    .pend  (pend),
    .ptr   (ptr),
    .gnt   (gnt),
    .id    (win),
    .valid (win_v)
  );

  assign grant = (state == IDLE) && bus.en && win_v;
  assign clr   = grant ? gnt : '0;

  // A fresh req wins over clear-on-grant.
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~clr) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= IDW'(N_REQ - 1);
      own   <= '0;
      pulse <= 1'b0;
      busy  <= 1'b0;
      done  <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (grant) begin
            ptr   <= win;
            own   <= win;
            pulse <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == P_END) begin
            pulse <= 1'b0;
            done  <= ONE << own;
            cnt   <= '0;
            if (GAP_LEN > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == G_END) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pending   = pend;
  assign bus.pulse_out = pulse;
  assign bus.owner     = own;
  assign bus.busy      = busy;
  assign bus.done      = done;

`ifdef PULSE_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr;

  // One count per cycle with any merged req; saturates.
  always_ff @(posedge clk) begin
    if (rst)
      ovr <= '0;
    else if (|(bus.req & pend) && ovr != 8'hFF)
      ovr <= ovr + 8'd1;
  end

  assign bus.overrun_cnt = ovr;
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb_pulse_sched: directed stimulus, queue scoreboard for
// pulse starts and done strobes, negedge monitor.
module tb_pulse_sched;

  localparam int N  = 4;
  localparam int PL = 32;
  localparam int GL = 2;

  typedef struct {
    int id;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ev_t pulse_q[$];
  ev_t done_q[$];

  pulse_sched_if #(.N_REQ(N)) bus ();

  pulse_sched #(
    .N_REQ     (N),
    .PULSE_LEN (PL),
    .GAP_LEN   (GL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic issue(input logic [N-1:0] v);
    bus.req = v;
    step();
    bus.req = '0;
  endtask

  task automatic exp_pulse(input int id, input int st);
    ev_t e;
    e.id  = id;
    e.cyc = st;
    pulse_q.push_back(e);
    e.cyc = st + PL;
    done_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((bus.busy || bus.pending != 0 || bus.pulse_out)
           && n < 1000) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(n < 1000), 1);
    step();
    step();
  endtask

  // Monitor: pulse rising edges, pulse length, done strobes.
  logic mprev = 1'b0;
  int   hi_cnt = 0;

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      mprev  = 1'b0;
      hi_cnt = 0;
    end else begin
      if (bus.pulse_out && !mprev) begin
        if (pulse_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pulse_unexpected: owner %0d at cyc %0d",
                   bus.owner, cyc);
        end else begin
          e = pulse_q.pop_front();
          chk("pulse_owner", int'(bus.owner), e.id);
          chk("pulse_start", cyc, e.cyc);
        end
      end
      if (bus.pulse_out) begin
        hi_cnt++;
      end else if (mprev) begin
        chk("pulse_len", hi_cnt, PL);
        hi_cnt = 0;
      end
      if (bus.done != '0) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: done %b at cyc %0d",
                   bus.done, cyc);
        end else begin
          e = done_q.pop_front();
          chk("done_vec", int'(bus.done), 1 << e.id);
          chk("done_cyc", cyc, e.cyc);
        end
      end
      mprev = bus.pulse_out;
    end
  end

  initial begin
    int e;
    int g;
    bus.en  = 1'b1;
    bus.req = '0;
    step();
    reset_dut();

    // Reset state.
    chk("rst_pending", int'(bus.pending), 0);
    chk("rst_pulse", int'(bus.pulse_out), 0);
    chk("rst_owner", int'(bus.owner), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
`ifdef PULSE_SCHED_OVERRUN_CNT_EN
    chk("rst_ovr", int'(bus.overrun_cnt), 0);
`endif

    // Single request from requester 2.
    e = cyc;
    g = e + 2;
    exp_pulse(2, g);
    issue(4'b0100);
    chk("single_pend", int'(bus.pending), 4'b0100);
    wait_to(g + 1);
    chk("single_owner", int'(bus.owner), 2);
    chk("single_pend_clr", int'(bus.pending), 0);
    wait_to(g + 33);
    chk("gap_busy", int'(bus.busy), 1);
    wait_to(g + 34);
    chk("idle_busy", int'(bus.busy), 0);
    wait_idle();

    // All four at once: 0,1,2,3 spaced PL+GL+1.
    reset_dut();
    e = cyc;
    for (int i = 0; i < N; i++)
      exp_pulse(i, e + 2 + i * (PL + GL + 1));
    issue(4'b1111);
    wait_idle();

    // Owner 1 re-triggers with 3 pending: 3 served first.
    reset_dut();
    e = cyc;
    g = e + 2;
    exp_pulse(1, g);
    exp_pulse(3, g + (PL + GL + 1));
    exp_pulse(1, g + 2 * (PL + GL + 1));
    issue(4'b0010);
    wait_to(e + 9);
    issue(4'b1010);
    chk("rr_pend", int'(bus.pending), 4'b1010);
    wait_idle();

    // Merge: three req[0] edges while held off, one pulse.
    reset_dut();
    bus.en  = 1'b0;
    bus.req = 4'b0001;
    step();
    step();
    step();
    bus.req = '0;
    chk("merge_pend", int'(bus.pending), 4'b0001);
`ifdef PULSE_SCHED_OVERRUN_CNT_EN
    chk("merge_ovr", int'(bus.overrun_cnt), 2);
`endif
    e = cyc;
    exp_pulse(0, e + 1);
    bus.en = 1'b1;
    wait_idle();

    // en gating for 50 clocks.
    bus.en = 1'b0;
    issue(4'b0010);
    repeat (50) step();
    chk("gate_pend", int'(bus.pending), 4'b0010);
    chk("gate_pulse", int'(bus.pulse_out), 0);
    chk("gate_busy", int'(bus.busy), 0);
    e = cyc;
    exp_pulse(1, e + 1);
    bus.en = 1'b1;
    wait_idle();

    // Reset at counter 10; pulse aborts with no done.
    e = cyc;
    g = e + 2;
    begin
      ev_t x;
      x.id  = 2;
      x.cyc = g;
      pulse_q.push_back(x);
    end
    issue(4'b0100);
    issue(4'b0001);
    wait_to(g + 10);
    rst = 1'b1;
    step();
    chk("rmid_pulse", int'(bus.pulse_out), 0);
    chk("rmid_pend", int'(bus.pending), 0);
    chk("rmid_done", int'(bus.done), 0);
    chk("rmid_busy", int'(bus.busy), 0);
    step();
    rst = 1'b0;
    e = cyc;
    exp_pulse(0, e + 2);
    exp_pulse(2, e + 2 + (PL + GL + 1));
    issue(4'b0101);
    wait_idle();

    repeat (4) step();
    chk("pulse_q_left", pulse_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
